// File: rtl/fb_pkg.sv
// Shared types and defaults for the double-buffered framebuffer.
// The optional auto-clear-after-swap feature is enabled with FB_AUTO_CLEAR_EN.
package fb_pkg;

    typedef enum logic {
        FB_IDLE = 1'b0,
        FB_FILL = 1'b1
    } fb_state_t;

    localparam int FB_DEF_DATA_WIDTH = 3;
    localparam int FB_DEF_WIDTH      = 160;
    localparam int FB_DEF_HEIGHT     = 120;

    function automatic int fb_depth(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/fb_dp_ram.sv
// Simple dual-port pixel RAM holding both pages; the address MSB selects the page.
// The registered read port returns the old word on a read-during-write.
module fb_dp_ram
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH:0]   waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH:0]   raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**(ADDR_WIDTH+1))-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/framebuffer_dbuf.sv
// Double-buffered framebuffer: writer targets the back page, scan-out reads the front page,
// pages swap on a vblank rise, and a fill engine paints the back page. Option: FB_AUTO_CLEAR_EN.
module framebuffer_dbuf
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DEF_DATA_WIDTH,
    parameter int FB_WIDTH   = FB_DEF_WIDTH,
    parameter int FB_HEIGHT  = FB_DEF_HEIGHT,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] q,
    input  logic                  vblank,
    input  logic                  swap_req,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_color,
    output logic                  busy,
    output logic                  swap_pending,
    output logic                  front_page,
    output logic                  swap_done
);

    localparam int                    DEPTH     = fb_depth(FB_WIDTH, FB_HEIGHT);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    fb_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;
    logic                  swap_pending_q, swap_pending_d;
    logic                  front_page_q, front_page_d;
    logic                  swap_done_q, swap_done_d;
    logic                  vblank_dly_q, vblank_dly_d;
    logic                  rd_ok_q, rd_ok_d;

    logic                  rise, swap_fire, auto_clear, wr_ok;
    logic                  ram_we;
    logic [ADDR_WIDTH:0]   ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

    assign rise      = vblank & ~vblank_dly_q;
    // A swap never lands while the fill owns the back page; it waits for a later vblank rise.
    assign swap_fire = rise & (swap_pending_q | swap_req) & (state_q == FB_IDLE);
    assign wr_ok     = ({1'b0, wr_addr} < DEPTH_W);

`ifdef FB_AUTO_CLEAR_EN
    assign auto_clear = swap_done_q & (state_q == FB_IDLE);
`else
    assign auto_clear = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        color_d        = color_q;
        swap_pending_d = swap_fire ? 1'b0 : (swap_pending_q | swap_req);
        front_page_d   = front_page_q ^ swap_fire;
        swap_done_d    = swap_fire;
        vblank_dly_d   = vblank;
        rd_ok_d        = ({1'b0, rd_addr} < DEPTH_W);
        case (state_q)
            FB_IDLE: begin
                if (auto_clear) begin
                    state_d = FB_FILL;
                    cnt_d   = '0;
                    color_d = '0;
                end else if (fill_start) begin
                    state_d = FB_FILL;
                    cnt_d   = '0;
                    color_d = fill_color;
                end
            end
            FB_FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = FB_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = FB_IDLE;
        endcase
    end

    // Write-port arbitration: the fill engine wins and user writes are dropped while it runs.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {~front_page_q, wr_addr};
        ram_wdata = wr_data;
        if (state_q == FB_FILL) begin
            ram_we    = 1'b1;
            ram_waddr = {~front_page_q, cnt_q};
            ram_wdata = color_q;
        end else if (we && wr_ok) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= FB_IDLE;
            cnt_q          <= '0;
            color_q        <= '0;
            swap_pending_q <= 1'b0;
            front_page_q   <= 1'b0;
            swap_done_q    <= 1'b0;
            vblank_dly_q   <= 1'b0;
            rd_ok_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            color_q        <= color_d;
            swap_pending_q <= swap_pending_d;
            front_page_q   <= front_page_d;
            swap_done_q    <= swap_done_d;
            vblank_dly_q   <= vblank_dly_d;
            rd_ok_q        <= rd_ok_d;
        end
    end

    fb_dp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr({front_page_q, rd_addr}),
        .rdata(ram_rdata)
    );

    // The RAM word is not reset, so out-of-range reads and the reset value are masked here.
    assign q            = rd_ok_q ? ram_rdata : '0;
    assign busy         = (state_q == FB_FILL);
    assign swap_pending = swap_pending_q;
    assign front_page   = front_page_q;
    assign swap_done    = swap_done_q;

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Self-checking bench for framebuffer_dbuf: vector table plus hand-written swap/fill/reset sequences.
// Honours FB_AUTO_CLEAR_EN when the design is built with it.
module tb_framebuffer_dbuf;

    localparam int DW    = 3;
    localparam int AW    = 15;
    localparam int DEPTH = 160 * 120;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, fill_color, q;
    logic          we, vblank, swap_req, fill_start;
    logic          busy, swap_pending, front_page, swap_done;

    int checks = 0;
    int errors = 0;
    logic model_fp;
    logic [DW-1:0] exp_q[$];

    typedef enum logic [1:0] {V_WR, V_RD, V_SWAP} vop_t;
    typedef struct {
        vop_t          op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs[13];

    framebuffer_dbuf dut (
        .clk(clk), .reset(reset), .wr_addr(wr_addr), .wr_data(wr_data), .we(we),
        .rd_addr(rd_addr), .q(q), .vblank(vblank), .swap_req(swap_req),
        .fill_start(fill_start), .fill_color(fill_color), .busy(busy),
        .swap_pending(swap_pending), .front_page(front_page), .swap_done(swap_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        rd_addr = a;
        exp_q.push_back(e);
        tick();
        check("read_q", {29'd0, q}, {29'd0, exp_q.pop_front()});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 25000) begin
            tick();
            n++;
        end
        if (busy) check(name, 32'd1, 32'd0);
    endtask

    // After swap_done has been observed: with auto-clear the new back page gets filled with 0.
    task automatic after_swap();
        tick();
        check("swap_done_clear", {31'd0, swap_done}, 32'd0);
`ifdef FB_AUTO_CLEAR_EN
        check("auto_clear_busy", {31'd0, busy}, 32'd1);
        wait_idle("auto_clear_timeout");
`endif
    endtask

    task automatic do_swap_rise(input logic with_req);
        if (with_req) begin
            swap_req = 1'b1;
            tick();
            swap_req = 1'b0;
            check("pending_set", {31'd0, swap_pending}, 32'd1);
        end
        vblank = 1'b1;
        tick();
        check("swap_done", {31'd0, swap_done}, 32'd1);
        check("front_page", {31'd0, front_page}, {31'd0, ~model_fp});
        check("pending_clr", {31'd0, swap_pending}, 32'd0);
        model_fp = ~model_fp;
        vblank = 1'b0;
        after_swap();
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        vblank = 1'b0; swap_req = 1'b0; fill_start = 1'b0; fill_color = '0;
        model_fp = 1'b0;
        vecs[0]  = '{V_WR, 15'd10,    3'd3, 3'd0};
        vecs[1]  = '{V_WR, 15'd11,    3'd7, 3'd0};
        vecs[2]  = '{V_WR, 15'd19199, 3'd5, 3'd0};
        vecs[3]  = '{V_WR, 15'd19200, 3'd1, 3'd0};
        vecs[4]  = '{V_WR, 15'd32767, 3'd4, 3'd0};
        vecs[5]  = '{V_RD, 15'd5,     3'd0, 3'd6};
        vecs[6]  = '{V_RD, 15'd19200, 3'd0, 3'd0};
        vecs[7]  = '{V_RD, 15'd32767, 3'd0, 3'd0};
        vecs[8]  = '{V_SWAP, 15'd0,   3'd0, 3'd0};
        vecs[9]  = '{V_RD, 15'd10,    3'd0, 3'd3};
        vecs[10] = '{V_RD, 15'd11,    3'd0, 3'd7};
        vecs[11] = '{V_RD, 15'd19199, 3'd0, 3'd5};
        vecs[12] = '{V_RD, 15'd5,     3'd0, 3'd0};

        // Reset state
        tick(); tick();
        check("rst_q", {29'd0, q}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pending", {31'd0, swap_pending}, 32'd0);
        check("rst_front", {31'd0, front_page}, 32'd0);
        check("rst_done", {31'd0, swap_done}, 32'd0);
        reset = 1'b0;
        tick();

        // Give address 5 a known value on both pages, ending with page 0 in front.
        do_write(15'd5, 3'd0);
        do_swap_rise(1'b1);
        do_write(15'd5, 3'd0);
        do_swap_rise(1'b1);

        // Basic back-page write, then swap to make it visible.
        do_write(15'd5, 3'h6);
        do_read(15'd5, 3'd0);
        do_swap_rise(1'b1);
        do_read(15'd5, 3'h6);

        for (int i = 0; i < 13; i++) begin
            case (vecs[i].op)
                V_WR:    do_write(vecs[i].addr, vecs[i].data);
                V_RD:    do_read(vecs[i].addr, vecs[i].exp);
                default: do_swap_rise(1'b1);
            endcase
        end

        // Fill of the back page, with a dropped write, a swap request and a vblank rise mid-fill.
        begin
            int n = 0;
            fill_color = 3'h2;
            fill_start = 1'b1;
            tick();
            fill_start = 1'b0;
            fill_color = 3'h5;
            while (busy && n < 20000) begin
                n++;
                we = (n == 50);
                wr_addr = 15'd10; wr_data = 3'd5;
                swap_req = (n == 100);
                vblank = (n == 200);
                if (n == 201) begin
                    check("midfill_front", {31'd0, front_page}, {31'd0, model_fp});
                    check("midfill_done", {31'd0, swap_done}, 32'd0);
                    check("midfill_pending", {31'd0, swap_pending}, 32'd1);
                end
                tick();
            end
            we = 1'b0; swap_req = 1'b0; vblank = 1'b0;
            check("fill_busy_cycles", n, DEPTH);
            tick();
            check("pending_after_fill", {31'd0, swap_pending}, 32'd1);
            do_swap_rise(1'b0);
            for (int a = 0; a < DEPTH; a++) do_read(AW'(a), 3'h2);
        end

        // swap_req coincident with the vblank rise
        swap_req = 1'b1; vblank = 1'b1;
        tick();
        check("coinc_done", {31'd0, swap_done}, 32'd1);
        check("coinc_front", {31'd0, front_page}, {31'd0, ~model_fp});
        check("coinc_pending", {31'd0, swap_pending}, 32'd0);
        model_fp = ~model_fp;
        swap_req = 1'b0; vblank = 1'b0;
        after_swap();

        // Request without vblank: nothing swaps until the next rise.
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick(); tick();
        check("noblank_front", {31'd0, front_page}, {31'd0, model_fp});
        check("noblank_pending", {31'd0, swap_pending}, 32'd1);
        do_swap_rise(1'b0);

        // Reset during a fill with a swap pending.
        check("front_before_reset", {31'd0, front_page}, {31'd0, model_fp});
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        fill_color = 3'h4;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (100) tick();
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_front", {31'd0, front_page}, 32'd0);
        check("rst_mid_pending", {31'd0, swap_pending}, 32'd0);
        model_fp = 1'b0;
        tick();
        reset = 1'b0;
        tick();

`ifdef FB_AUTO_CLEAR_EN
        // Both swaps clear the page that becomes the back page, so the front reads 0.
        do_swap_rise(1'b1);
        do_swap_rise(1'b1);
        for (int a = 0; a < 16; a++) do_read(AW'(a * 1000), 3'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
